// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard unit:
//   FWD_RF / FWD_W / FWD_M : operand-select codes for ForwardAE/ForwardBE
//   hz_state_t             : load-use sequencer states
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    LDSTALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous reset and clear.
// Ports:
//   clk   in  : clock
//   reset in  : synchronous active-high reset (q -> 0)
//   clr   in  : synchronous clear, wins over inc
//   inc   in  : count enable; the count sticks at all-ones
//   q     out : current count (CNT_W bits)
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard unit for the 5-stage F/D/E/M/W pipeline. Drives forwarding selects,
// every pipeline-register stall/flush, sequences multi-bubble load-use stalls
// and keeps saturating stall/flush performance counters.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   Rs1D..RdW                  : stage register addresses
//   RegWriteE/M/W, LoadE       : stage write-back / load flags
//   PCSrcE                     : taken branch/jump in E
//   MduValidE, MduDoneE        : multi-cycle op in E and its completion
//   DmemReqM, DmemReadyM       : data-memory access in M and its completion
//   ClrCnt                     : clear both performance counters
//   ForwardAE, ForwardBE       : E operand select (hazard_pkg FWD_*)
//   StallF/D/E/M, FlushD/E/M/W : pipeline register hold / bubble
//   StallCnt, FlushCnt         : cycles with StallF, cycles with branch flush
//
// state   | meaning
// RUN     | normal issue; a load-use hazard inserts the first bubble here
// LDSTALL | extra load-use bubbles pending, BubCnt holds how many remain
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter bit          FWD_EN       = 1'b1,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MduValidE,
  input  logic              MduDoneE,
  input  logic              DmemReqM,
  input  logic              DmemReadyM,
  input  logic              ClrCnt,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int unsigned BW = $clog2(LOAD_BUBBLES + 1);
  localparam logic [BW-1:0] BUB_INIT = BW'(LOAD_BUBBLES - 1);
  localparam logic [BW-1:0] BUB_LAST = BW'(1);

  hz_state_t     state_q, state_d;
  logic [BW-1:0] bub_cnt_q, bub_cnt_d;

  logic mem_wait, mdu_wait, load_use, raw_stall, take_lu, branch_flush;

  // x0 is hard-wired, so a zero source never matches anything.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (FWD_EN && (rs != '0)) begin
      if (RegWriteM && (RdM == rs)) begin
        sel = FWD_M;
      end else if (RegWriteW && (RdW == rs)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  function automatic logic src_hit(input logic [REG_AW-1:0] rs,
                                   input logic              we,
                                   input logic [REG_AW-1:0] rd);
    return we && (rd != '0) && (rs == rd);
  endfunction

  assign mem_wait = DmemReqM & ~DmemReadyM;
  assign mdu_wait = MduValidE & ~MduDoneE;
  assign load_use = LoadE & src_hit(Rs1D, RegWriteE, RdE) |
                    LoadE & src_hit(Rs2D, RegWriteE, RdE);
  // Without forwarding, W needs no stall: the register file writes in the
  // first half-cycle and D reads in the second.
  assign raw_stall = !FWD_EN && (src_hit(Rs1D, RegWriteE, RdE) ||
                                 src_hit(Rs2D, RegWriteE, RdE) ||
                                 src_hit(Rs1D, RegWriteM, RdM) ||
                                 src_hit(Rs2D, RegWriteM, RdM));
  assign take_lu = load_use & ~mem_wait & ~mdu_wait;

  always_comb begin
    ForwardAE    = FWD_RF;
    ForwardBE    = FWD_RF;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushM       = 1'b0;
    FlushW       = 1'b0;
    branch_flush = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      if (mem_wait) begin
        // A taken branch in E simply waits here and acts after release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (mdu_wait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (load_use || (state_q == LDSTALL) || raw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (PCSrcE) begin
        FlushD       = 1'b1;
        FlushE       = 1'b1;
        branch_flush = 1'b1;
      end
    end
  end

  // The load itself may be stuck in M, so MemWait freezes the sequencer.
  always_comb begin
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    case (state_q)
      RUN: begin
        if (take_lu && (LOAD_BUBBLES > 1)) begin
          state_d   = LDSTALL;
          bub_cnt_d = BUB_INIT;
        end
      end
      LDSTALL: begin
        if (!mem_wait) begin
          bub_cnt_d = bub_cnt_q - 1'b1;
          if (bub_cnt_q == BUB_LAST) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d   = RUN;
        bub_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      bub_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ClrCnt),
    .inc   (StallF),
    .q     (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ClrCnt),
    .inc   (branch_flush),
    .q     (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances share every input.
//   dut_a : FWD_EN=1, LOAD_BUBBLES=3, CNT_W=4
//   dut_b : FWD_EN=0, LOAD_BUBBLES=1, CNT_W=16
// A priority-rule model predicts both instances every cycle; directed
// sequences add hand-computed expectations.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE;
  logic       MduValidE, MduDoneE, DmemReqM, DmemReadyM, ClrCnt;

  // {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}
  logic [11:0] a_o, b_o;
  logic [3:0]  a_sc, a_fc;
  logic [15:0] b_sc, b_fc;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .LOAD_BUBBLES(3), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MduValidE(MduValidE), .MduDoneE(MduDoneE),
    .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM), .ClrCnt(ClrCnt),
    .ForwardAE(a_o[11:10]), .ForwardBE(a_o[9:8]),
    .StallF(a_o[7]), .StallD(a_o[6]), .StallE(a_o[5]), .StallM(a_o[4]),
    .FlushD(a_o[3]), .FlushE(a_o[2]), .FlushM(a_o[1]), .FlushW(a_o[0]),
    .StallCnt(a_sc), .FlushCnt(a_fc)
  );

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .LOAD_BUBBLES(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MduValidE(MduValidE), .MduDoneE(MduDoneE),
    .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM), .ClrCnt(ClrCnt),
    .ForwardAE(b_o[11:10]), .ForwardBE(b_o[9:8]),
    .StallF(b_o[7]), .StallD(b_o[6]), .StallE(b_o[5]), .StallM(b_o[4]),
    .FlushD(b_o[3]), .FlushE(b_o[2]), .FlushM(b_o[1]), .FlushW(b_o[0]),
    .StallCnt(b_sc), .FlushCnt(b_fc)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // left_x = load-use bubbles still owed after the current cycle.
  int la = 0, lb = 0;
  int sa = 0, fa = 0, sb = 0, fb = 0;

  function automatic logic [1:0] fwd_of(input logic [4:0] rs, input bit en);
    if (!en || rs == 5'd0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit hit(input logic [4:0] rs, input logic we, input logic [4:0] rd);
    return we && rd != 5'd0 && rs == rd;
  endfunction

  function automatic bit lu_now();
    return LoadE && (hit(Rs1D, RegWriteE, RdE) || hit(Rs2D, RegWriteE, RdE));
  endfunction

  function automatic logic [11:0] mdl(input bit en, input int left, output bit br);
    logic [3:0] st, fl;
    bit raw;
    br = 1'b0;
    st = 4'b0000;
    fl = 4'b0000;
    if (reset) return 12'h00F;
    raw = !en && (hit(Rs1D, RegWriteE, RdE) || hit(Rs2D, RegWriteE, RdE) ||
                  hit(Rs1D, RegWriteM, RdM) || hit(Rs2D, RegWriteM, RdM));
    if (DmemReqM && !DmemReadyM) begin
      st = 4'b1111; fl = 4'b0001;
    end else if (MduValidE && !MduDoneE) begin
      st = 4'b1110; fl = 4'b0010;
    end else if (left > 0 || lu_now() || raw) begin
      st = 4'b1100; fl = 4'b0100;
    end else if (PCSrcE) begin
      fl = 4'b1100; br = 1'b1;
    end
    return {fwd_of(Rs1E, en), fwd_of(Rs2E, en), st, fl};
  endfunction

  function automatic int nxt_left(input int left, input int nb);
    if (DmemReqM && !DmemReadyM) return left;
    if (left > 0) return left - 1;
    if (!(MduValidE && !MduDoneE) && lu_now()) return nb - 1;
    return 0;
  endfunction

  function automatic int sat(input int v, input bit inc, input int mx);
    if (ClrCnt) return 0;
    if (inc && v < mx) return v + 1;
    return v;
  endfunction

  always @(posedge clk) begin
    bit br_a, br_b;
    logic [11:0] oa, ob;
    if (reset) begin
      la = 0; lb = 0; sa = 0; fa = 0; sb = 0; fb = 0;
    end else begin
      oa = mdl(1'b1, la, br_a);
      ob = mdl(1'b0, lb, br_b);
      sa = sat(sa, oa[7], 15);
      fa = sat(fa, br_a, 15);
      sb = sat(sb, ob[7], 65535);
      fb = sat(fb, br_b, 65535);
      la = nxt_left(la, 3);
      lb = nxt_left(lb, 1);
    end
  end

  always @(negedge clk) begin
    bit br;
    chk("a_outputs", {20'd0, a_o}, {20'd0, mdl(1'b1, la, br)});
    chk("b_outputs", {20'd0, b_o}, {20'd0, mdl(1'b0, lb, br)});
    chk("a_stallcnt", a_sc, sa);
    chk("a_flushcnt", a_fc, fa);
    chk("b_stallcnt", b_sc, sb);
    chk("b_flushcnt", b_fc, fb);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
    MduValidE = 0; MduDoneE = 0; DmemReqM = 0; DmemReadyM = 1; ClrCnt = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_7();
    LoadE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
  endtask

  initial begin
    idle();
    reset = 1;
    Rs1E = 5; RdM = 5; RegWriteM = 1;
    @(negedge clk);
    chk("rst_flush", a_o[3:0], 4'hF);
    chk("rst_stall", a_o[7:4], 4'h0);
    chk("rst_fwd", a_o[11:10], FWD_RF);
    nxt();
    nxt();
    reset = 0;

    // forwarding and x0
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    @(negedge clk);
    chk("fwd_m", a_o[11:10], FWD_M);
    chk("fwd_disabled", b_o[11:10], FWD_RF);
    nxt();
    RegWriteM = 0; Rs2E = 5;
    @(negedge clk);
    chk("fwd_w", a_o[11:10], FWD_W);
    chk("fwd_w_b", a_o[9:8], FWD_W);
    nxt();
    Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1; Rs2E = 0;
    @(negedge clk);
    chk("fwd_x0", a_o[11:10], FWD_RF);

    // load-use, 3 bubbles
    nxt();
    idle();
    load_use_7();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("lu_stall_%0d", i), {a_o[7], a_o[6], a_o[2]}, (i < 3) ? 3'b111 : 3'b000);
      nxt();
      LoadE = 0; RegWriteE = 0; RdE = 0;
    end
    @(negedge clk);
    chk("lu_stallcnt", a_sc, 3);

    // MemWait during bubble 2
    nxt();
    idle();
    ClrCnt = 1;
    nxt();
    ClrCnt = 0;
    load_use_7();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        LoadE = 0; RegWriteE = 0; RdE = 0;
      end
      DmemReqM = (c == 1 || c == 2);
      DmemReadyM = !(c == 1 || c == 2);
      @(negedge clk);
      chk($sformatf("mw_cycle_%0d", c), {a_o[7], a_o[4], a_o[0]},
          (c == 1 || c == 2) ? 3'b111 : ((c < 5) ? 3'b100 : 3'b000));
      nxt();
    end
    idle();
    @(negedge clk);
    chk("mw_stallcnt", a_sc, 5);

    // MDU hold then done together with branch
    nxt();
    ClrCnt = 1;
    nxt();
    ClrCnt = 0;
    MduValidE = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mdu_hold_%0d", c), {a_o[5], a_o[1], a_o[7]}, 3'b111);
      nxt();
    end
    MduDoneE = 1; PCSrcE = 1;
    @(negedge clk);
    chk("mdu_done_br", {a_o[7], a_o[5], a_o[3], a_o[2]}, 4'b0011);
    nxt();
    idle();
    @(negedge clk);
    chk("br_flushcnt_a", a_fc, 1);
    chk("br_flushcnt_b", b_fc, 1);
    chk("mdu_stallcnt", a_sc, 4);

    // no-forwarding RAW
    nxt();
    Rs1D = 9; RdM = 9; RegWriteM = 1;
    @(negedge clk);
    chk("raw_m_b", {b_o[7], b_o[6], b_o[2]}, 3'b111);
    chk("raw_m_a", a_o[7], 1'b0);
    nxt();
    RdM = 0; RegWriteM = 0; RdW = 9; RegWriteW = 1;
    @(negedge clk);
    chk("raw_w_b", b_o[7], 1'b0);

    // saturation and clear precedence
    nxt();
    idle();
    ClrCnt = 1;
    nxt();
    ClrCnt = 0;
    MduValidE = 1;
    repeat (20) nxt();
    @(negedge clk);
    chk("sat_stall_a", a_sc, 15);
    chk("sat_stall_b", b_sc, 20);
    ClrCnt = 1;
    nxt();
    ClrCnt = 0; MduValidE = 0;
    @(negedge clk);
    chk("clr_precedence", a_sc, 0);
    PCSrcE = 1;
    repeat (18) nxt();
    PCSrcE = 0;
    @(negedge clk);
    chk("sat_flush_a", a_fc, 15);

    // reset in the middle of LDSTALL
    nxt();
    idle();
    load_use_7();
    nxt();
    idle();
    Rs2D = 7; reset = 1;
    @(negedge clk);
    chk("rst_mid_flush", a_o[3:0], 4'hF);
    chk("rst_mid_stall", a_o[7:4], 4'h0);
    nxt();
    reset = 0;
    @(negedge clk);
    chk("rst_mid_run", a_o[7], 1'b0);
    chk("rst_mid_cnt", {a_sc, a_fc}, 8'h00);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nxt();
      reset      = ($urandom_range(0, 63) == 0);
      ClrCnt     = ($urandom_range(0, 31) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      LoadE      = ($urandom_range(0, 2) == 0);
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MduValidE  = ($urandom_range(0, 3) == 0);
      MduDoneE   = 1'($urandom_range(0, 1));
      DmemReqM   = ($urandom_range(0, 3) == 0);
      DmemReadyM = 1'($urandom_range(0, 1));
    end
    nxt();
    idle();
    reset = 0;
    @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard unit for the 5-stage pipeline (F/D/E/M/W). It supersedes the purely combinational hazard logic with:
- x0-aware forwarding and an optional no-forwarding mode;
- a multi-bubble load-use stall sequencer;
- freeze control for a multi-cycle MDU in E and a handshaked data memory in M;
- saturating stall/flush performance counters.

It sits beside the datapath and drives every pipeline-register enable/clear.

## Interface
- `REG_AW`, 5: register-address width.
- `FWD_EN`, 1: 1 = forward from M/W; 0 = stall D on any RAW with E/M.
- `LOAD_BUBBLES`, 1: bubbles inserted per load-use hazard; must be ≥1.
- `CNT_W`, 16: performance-counter width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `Rs1D`, `Rs2D`, `Rs1E`, `Rs2E`, `RdE`, `RdM`, `RdW` in `REG_AW`: stage register addresses.
- `RegWriteE`, `RegWriteM`, `RegWriteW` in 1: stage writes a register.
- `LoadE` in 1: instruction in E is a load.
- `PCSrcE` in 1: taken branch/jump in E.
- `MduValidE` in 1: multi-cycle op in E; `MduDoneE` in 1: its result is ready this cycle.
- `DmemReqM` in 1: memory access in M; `DmemReadyM` in 1: memory completes this cycle.
- `ClrCnt` in 1: synchronous clear of the counters.
- `ForwardAE`, `ForwardBE` out 2: 00 register file, 01 W result, 10 M ALU result.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold stage register.
- `FlushD`, `FlushE`, `FlushM`, `FlushW` out 1: clear stage register to a bubble.
- `StallCnt`, `FlushCnt` out `CNT_W`: cycles with `StallF`=1; cycles with a branch flush.

## Operation
- Register 0 never matches: a source or destination of 0 produces no forwarding and no stall.
- **Forwarding** (only when `FWD_EN`=1):
  - M match with `RegWriteM` gives 10.
  - Otherwise, W match with `RegWriteW` gives 01.
  - Otherwise 00.
  - With `FWD_EN`=0, both Forward outputs are 00.
- Hazard conditions, evaluated in priority order (highest first):
  1. **MemWait** = `DmemReqM` & !`DmemReadyM`. Stall F, D, E, M; flush W. `PCSrcE` is ignored; the branch acts after release.
  2. **MduWait** = `MduValidE` & !`MduDoneE`. Stall F, D, E; flush M.
  3. **LoadUse**, or state LDSTALL. Stall F, D; flush E. LoadUse = `LoadE` & `RegWriteE` & `RdE`≠0 & (`Rs1D`==`RdE` | `Rs2D`==`RdE`).
  4. **RawStall** (only when `FWD_EN`=0): a D source matches `RdE` or `RdM` with its RegWrite set. Stall F, D; flush E. W is excluded because the register file writes in the first half-cycle.
  5. **Branch** = `PCSrcE`. Flush D and E.
- **FSM**: states RUN and LDSTALL, with a bubble counter `BubCnt` of width clog2(`LOAD_BUBBLES`+1).
  - RUN → LDSTALL when LoadUse is taken at priority 3 and `LOAD_BUBBLES`>1; `BubCnt` loads `LOAD_BUBBLES`-1.
  - In LDSTALL, `BubCnt` decrements on every cycle without MemWait. When `BubCnt`==1 and it decrements, the FSM returns to RUN next cycle.
  - During MemWait, state and `BubCnt` hold, since the load itself may be waiting in M.
- **Counters**: `StallCnt` increments when `StallF`=1. `FlushCnt` increments when `FlushD` is caused by Branch. Both saturate at all-ones. `ClrCnt` zeroes both and takes precedence over increment.

## Timing
- Stall, flush and Forward outputs are combinational from the inputs and the registered state.
- FSM state, `BubCnt` and the counters update on the rising edge of `clk`.
- Total load-use penalty is exactly `LOAD_BUBBLES` cycles plus any MemWait cycles.
- MDU release: on the cycle `MduDoneE`=1, no stall is asserted from priority 2.
- MduValidE & MduDoneE in the same cycle: zero stall.
- **Reset** (while `reset`=1 and after it is sampled):
  - state RUN, `BubCnt`=0, counters 0;
  - outputs: Forward 00, all Stall 0, all Flush 1.
- A reset mid-LDSTALL or mid-MemWait aborts the sequence; the next cycle runs in RUN.

## Structure
- Package `hazard_pkg`:
  - Forward-select constants `FWD_RF`=2'b00, `FWD_W`=2'b01, `FWD_M`=2'b10;
  - the `hz_state_t` enum {RUN, LDSTALL}.
- Sub-module `sat_counter` (`CNT_W`; ports `clk`, `reset`, `clr`, `inc`, `q`), instantiated twice.
- Everything else lives in `hazard_ctrl`.

## Test plan
- **Forwarding, x0**: `Rs1E`=5, `RdM`=5, `RegWriteM`=1, `RdW`=5, `RegWriteW`=1 → `ForwardAE`=10. Repeat with `Rs1E`=`RdM`=0 → 00.
- **Load-use**: `LOAD_BUBBLES`=3, `LoadE`=1, `RdE`=7, `Rs2D`=7 → `StallF`/`StallD`/`FlushE`=1 for exactly 3 cycles, then 0. `StallCnt`=3.
- **MemWait inside LDSTALL**: `DmemReadyM`=0 for 2 cycles during bubble 2 → F–M frozen, `FlushW`=1. Bubble count resumes afterwards; `StallF` high for 5 cycles in total.
- **MDU plus branch**: `MduValidE`=1 with `MduDoneE` low for 4 cycles → `StallE`=1, `FlushM`=1 for 4 cycles. On the done cycle, `PCSrcE`=1 → `FlushD`=`FlushE`=1 and `FlushCnt`=1.
- **FWD_EN=0**: `Rs1D`=9, `RdM`=9, `RegWriteM`=1 → stall F/D and flush E. The same match only on `RdW` → no stall.
- **Reset and counters**: drive counters to saturation with `CNT_W`=4 → they hold at 15. Assert `reset` mid-LDSTALL → next cycle RUN, counters 0, all Flush=1 while reset is held.
